// File: rtl/mmu_axi_pkg.sv
// Shared definitions for the AXI MMU address front end: per-channel FSM
// state encoding, AXI burst type constants and default bus widths.
package mmu_axi_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_ID_W   = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ISSUE = 2'd3
  } xlat_state_e;

endpackage

// File: rtl/axi_addr_xlate_chan.sv
// One address channel (AR or AW) of the MMU front end.
// Accepts an upstream beat, asks the translator for a physical address,
// waits for done (retrying on timeout), then presents the beat downstream
// with the translated address.
// Ports:
//   clk, reset_             clock, async active-low reset
//   s_*_i / s_valid_i / s_ready_o   upstream address beat + handshake
//   m_*_o / m_valid_o / m_ready_i   downstream address beat + handshake
//   v_addr_o/v_len_o/v_size_o       virtual request to translator
//   req_o                           one-cycle translation request
//   p_addr_i / done_i               translator response
//   err_o                           sticky timeout flag
module axi_addr_xlate_chan
  import mmu_axi_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ID_W    = DEF_ID_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [ID_W-1:0]   s_id_i,
  input  logic [ADDR_W-1:0] s_addr_i,
  input  logic [7:0]        s_len_i,
  input  logic [2:0]        s_size_i,
  input  logic [1:0]        s_burst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [ID_W-1:0]   m_id_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [7:0]        m_len_o,
  output logic [2:0]        m_size_o,
  output logic [1:0]        m_burst_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [ADDR_W-1:0] v_addr_o,
  output logic [7:0]        v_len_o,
  output logic [2:0]        v_size_o,
  output logic              req_o,
  input  logic [ADDR_W-1:0] p_addr_i,
  input  logic              done_i,
  output logic              err_o
);

  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  xlat_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              cap_en, lat_en;

  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] vaddr_q, paddr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    cap_en  = 1'b0;
    lat_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_valid_i && ready_q) begin
          cap_en  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done has priority over an expiring counter in the same cycle
        if (done_i) begin
          lat_en  = 1'b1;
          state_d = ST_ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ISSUE: begin
        if (m_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered so ready stays low while reset is asserted and rises on
    // the first edge after release.
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      id_q    <= '0;
      vaddr_q <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      paddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      if (cap_en) begin
        id_q    <= s_id_i;
        vaddr_q <= s_addr_i;
        len_q   <= s_len_i;
        size_q  <= s_size_i;
        burst_q <= s_burst_i;
      end
      if (lat_en) paddr_q <= p_addr_i;
    end
  end

  assign s_ready_o = ready_q;
  assign m_valid_o = (state_q == ST_ISSUE);
  assign req_o     = (state_q == ST_REQ);
  assign err_o     = err_q;
  assign m_id_o    = id_q;
  assign m_addr_o  = paddr_q;
  assign m_len_o   = len_q;
  assign m_size_o  = size_q;
  assign m_burst_o = burst_q;
  assign v_addr_o  = vaddr_q;
  assign v_len_o   = len_q;
  assign v_size_o  = size_q;

endmodule

// File: rtl/axi_addr_xlate_stage.sv
// Address-channel front end of the AXI MMU. Read (AR) and write (AW)
// channels each run an independent translate-and-reissue FSM; only the
// address is replaced, id/len/size/burst pass through.
// Ports:
//   clk, reset_                      clock, async active-low reset
//   s_axi_ar* / s_axi_aw*            upstream address channels
//   m_axi_ar* / m_axi_aw*            downstream (physical) address channels
//   v_raddr,r_len,r_size / v_waddr,w_len,w_size   virtual request to translator
//   xlat_rreq / xlat_wreq            one-cycle translation request
//   p_raddr,t_rdone / p_waddr,t_wdone translator responses
//   xlat_rerr / xlat_werr            sticky timeout flags
module axi_addr_xlate_stage
  import mmu_axi_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ID_W    = DEF_ID_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ID_W-1:0]   m_axi_awid,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [ADDR_W-1:0] v_raddr,
  output logic [7:0]        r_len,
  output logic [2:0]        r_size,
  output logic [ADDR_W-1:0] v_waddr,
  output logic [7:0]        w_len,
  output logic [2:0]        w_size,
  output logic              xlat_rreq,
  output logic              xlat_wreq,
  input  logic [ADDR_W-1:0] p_raddr,
  input  logic [ADDR_W-1:0] p_waddr,
  input  logic              t_rdone,
  input  logic              t_wdone,
  output logic              xlat_rerr,
  output logic              xlat_werr
);

  axi_addr_xlate_chan #(.ADDR_W(ADDR_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) u_ar (
    .clk       (clk),
    .reset_    (reset_),
    .s_id_i    (s_axi_arid),
    .s_addr_i  (s_axi_araddr),
    .s_len_i   (s_axi_arlen),
    .s_size_i  (s_axi_arsize),
    .s_burst_i (s_axi_arburst),
    .s_valid_i (s_axi_arvalid),
    .s_ready_o (s_axi_arready),
    .m_id_o    (m_axi_arid),
    .m_addr_o  (m_axi_araddr),
    .m_len_o   (m_axi_arlen),
    .m_size_o  (m_axi_arsize),
    .m_burst_o (m_axi_arburst),
    .m_valid_o (m_axi_arvalid),
    .m_ready_i (m_axi_arready),
    .v_addr_o  (v_raddr),
    .v_len_o   (r_len),
    .v_size_o  (r_size),
    .req_o     (xlat_rreq),
    .p_addr_i  (p_raddr),
    .done_i    (t_rdone),
    .err_o     (xlat_rerr)
  );

  axi_addr_xlate_chan #(.ADDR_W(ADDR_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) u_aw (
    .clk       (clk),
    .reset_    (reset_),
    .s_id_i    (s_axi_awid),
    .s_addr_i  (s_axi_awaddr),
    .s_len_i   (s_axi_awlen),
    .s_size_i  (s_axi_awsize),
    .s_burst_i (s_axi_awburst),
    .s_valid_i (s_axi_awvalid),
    .s_ready_o (s_axi_awready),
    .m_id_o    (m_axi_awid),
    .m_addr_o  (m_axi_awaddr),
    .m_len_o   (m_axi_awlen),
    .m_size_o  (m_axi_awsize),
    .m_burst_o (m_axi_awburst),
    .m_valid_o (m_axi_awvalid),
    .m_ready_i (m_axi_awready),
    .v_addr_o  (v_waddr),
    .v_len_o   (w_len),
    .v_size_o  (w_size),
    .req_o     (xlat_wreq),
    .p_addr_i  (p_waddr),
    .done_i    (t_wdone),
    .err_o     (xlat_werr)
  );

endmodule

// File: tb/tb_axi_addr_xlate_stage.sv
// Bench for axi_addr_xlate_stage. Two instances share all inputs: dut with
// the default timeout, dut16 with TIMEOUT=16 for the retry cases.
module tb_axi_addr_xlate_stage;
  import mmu_axi_pkg::*;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic [3:0]  s_axi_arid = '0, s_axi_awid = '0;
  logic [31:0] s_axi_araddr = '0, s_axi_awaddr = '0;
  logic [7:0]  s_axi_arlen = '0, s_axi_awlen = '0;
  logic [2:0]  s_axi_arsize = '0, s_axi_awsize = '0;
  logic [1:0]  s_axi_arburst = '0, s_axi_awburst = '0;
  logic        s_axi_arvalid = 1'b0, s_axi_awvalid = 1'b0;
  logic        m_axi_arready = 1'b1, m_axi_awready = 1'b1;
  logic [31:0] p_raddr, p_waddr;
  logic        t_rdone, t_wdone;

  // dut outputs
  logic        s_axi_arready, s_axi_awready;
  logic [3:0]  m_axi_arid, m_axi_awid;
  logic [31:0] m_axi_araddr, m_axi_awaddr;
  logic [7:0]  m_axi_arlen, m_axi_awlen;
  logic [2:0]  m_axi_arsize, m_axi_awsize;
  logic [1:0]  m_axi_arburst, m_axi_awburst;
  logic        m_axi_arvalid, m_axi_awvalid;
  logic [31:0] v_raddr, v_waddr;
  logic [7:0]  r_len, w_len;
  logic [2:0]  r_size, w_size;
  logic        xlat_rreq, xlat_wreq, xlat_rerr, xlat_werr;

  // dut16 outputs
  logic        b_s_axi_arready, b_s_axi_awready;
  logic [3:0]  b_m_axi_arid, b_m_axi_awid;
  logic [31:0] b_m_axi_araddr, b_m_axi_awaddr;
  logic [7:0]  b_m_axi_arlen, b_m_axi_awlen;
  logic [2:0]  b_m_axi_arsize, b_m_axi_awsize;
  logic [1:0]  b_m_axi_arburst, b_m_axi_awburst;
  logic        b_m_axi_arvalid, b_m_axi_awvalid;
  logic [31:0] b_v_raddr, b_v_waddr;
  logic [7:0]  b_r_len, b_w_len;
  logic [2:0]  b_r_size, b_w_size;
  logic        b_xlat_rreq, b_xlat_wreq, b_xlat_rerr, b_xlat_werr;

  // translator model (dut only) and manual overrides
  logic        mdl_en = 1'b1;
  logic        mdl_rdone = 1'b0, mdl_wdone = 1'b0;
  logic [31:0] mdl_raddr = '0, mdl_waddr = '0, rv = '0, wv = '0;
  int          rcnt = 0, wcnt = 0;
  logic        man_rdone = 1'b0, man_wdone = 1'b0;
  logic [31:0] man_raddr = '0, man_waddr = '0;

  assign t_rdone = mdl_rdone | man_rdone;
  assign t_wdone = mdl_wdone | man_wdone;
  assign p_raddr = man_rdone ? man_raddr : mdl_raddr;
  assign p_waddr = man_wdone ? man_waddr : mdl_waddr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_addr_xlate_stage dut (
    .clk(clk), .reset_(reset_),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .v_raddr(v_raddr), .r_len(r_len), .r_size(r_size),
    .v_waddr(v_waddr), .w_len(w_len), .w_size(w_size),
    .xlat_rreq(xlat_rreq), .xlat_wreq(xlat_wreq),
    .p_raddr(p_raddr), .p_waddr(p_waddr), .t_rdone(t_rdone), .t_wdone(t_wdone),
    .xlat_rerr(xlat_rerr), .xlat_werr(xlat_werr)
  );

  axi_addr_xlate_stage #(.TIMEOUT(16)) dut16 (
    .clk(clk), .reset_(reset_),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(b_s_axi_arready),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(b_s_axi_awready),
    .m_axi_arid(b_m_axi_arid), .m_axi_araddr(b_m_axi_araddr), .m_axi_arlen(b_m_axi_arlen),
    .m_axi_arsize(b_m_axi_arsize), .m_axi_arburst(b_m_axi_arburst),
    .m_axi_arvalid(b_m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_awid(b_m_axi_awid), .m_axi_awaddr(b_m_axi_awaddr), .m_axi_awlen(b_m_axi_awlen),
    .m_axi_awsize(b_m_axi_awsize), .m_axi_awburst(b_m_axi_awburst),
    .m_axi_awvalid(b_m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .v_raddr(b_v_raddr), .r_len(b_r_len), .r_size(b_r_size),
    .v_waddr(b_v_waddr), .w_len(b_w_len), .w_size(b_w_size),
    .xlat_rreq(b_xlat_rreq), .xlat_wreq(b_xlat_wreq),
    .p_raddr(p_raddr), .p_waddr(p_waddr), .t_rdone(t_rdone), .t_wdone(t_wdone),
    .xlat_rerr(b_xlat_rerr), .xlat_werr(b_xlat_werr)
  );

  // Translator: request seen in cycle r -> done driven during cycle r+40,
  // p = v + 0x1000 (read) / v + 0x1100 (write).
  always @(negedge clk) begin
    if (!mdl_en) begin
      rcnt <= 0; wcnt <= 0; mdl_rdone <= 1'b0; mdl_wdone <= 1'b0;
    end else begin
      mdl_rdone <= (rcnt == 1);
      mdl_wdone <= (wcnt == 1);
      if (rcnt == 1) mdl_raddr <= rv + 32'h1000;
      if (wcnt == 1) mdl_waddr <= wv + 32'h1100;
      if (xlat_rreq) begin rv <= v_raddr; rcnt <= 40; end
      else if (rcnt > 0) rcnt <= rcnt - 1;
      if (xlat_wreq) begin wv <= v_waddr; wcnt <= 40; end
      else if (wcnt > 0) wcnt <= wcnt - 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[4];

  // Full transaction through dut with the translator model.
  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    if (!v.wr) begin
      s_axi_arid = v.id; s_axi_araddr = v.addr; s_axi_arlen = v.len;
      s_axi_arsize = v.size; s_axi_arburst = v.burst; s_axi_arvalid = 1'b1;
    end else begin
      s_axi_awid = v.id; s_axi_awaddr = v.addr; s_axi_awlen = v.len;
      s_axi_awsize = v.size; s_axi_awburst = v.burst; s_axi_awvalid = 1'b1;
    end
    chk("accept_ready", v.wr ? s_axi_awready : s_axi_arready, 64'd1);
    @(posedge clk); #1 s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
    @(negedge clk); lat = 1;
    chk("req_cycle1", v.wr ? xlat_wreq : xlat_rreq, 64'd1);
    chk("xlat_req_fields", v.wr ? {v_waddr, w_len, w_size} : {v_raddr, r_len, r_size},
        {v.addr, v.len, v.size});
    @(negedge clk); lat = 2;
    chk("req_one_cycle", v.wr ? xlat_wreq : xlat_rreq, 64'd0);
    while (!(v.wr ? m_axi_awvalid : m_axi_arvalid) && lat < 100) begin
      @(negedge clk); lat++;
    end
    chk("latency", lat, 64'd42);
    chk("m_addr", v.wr ? m_axi_awaddr : m_axi_araddr, v.exp_addr);
    chk("m_passthru", v.wr ? {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst}
                           : {m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst},
        {v.id, v.len, v.size, v.burst});
    @(negedge clk);
    chk("post_handshake", v.wr ? {m_axi_awvalid, s_axi_awready} : {m_axi_arvalid, s_axi_arready},
        64'b01);
  endtask

  task automatic do_reset();
    @(negedge clk); reset_ = 1'b0;
    @(negedge clk); reset_ = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    tbl[0] = '{1'b0, 4'h5, 32'h0000_2000, 8'd3,   3'd2, BURST_INCR,  32'h0000_3000};
    tbl[1] = '{1'b1, 4'hA, 32'h0000_8000, 8'd0,   3'd3, BURST_FIXED, 32'h0000_9100};
    tbl[2] = '{1'b0, 4'hF, 32'hFFFF_F000, 8'd255, 3'd7, BURST_WRAP,  32'h0000_0000};
    tbl[3] = '{1'b1, 4'h1, 32'h1234_5670, 8'd7,   3'd1, BURST_INCR,  32'h1234_6770};

    // reset state
    #3;
    chk("rst_ready", {s_axi_arready, s_axi_awready}, 64'b00);
    chk("rst_valid_req_err", {m_axi_arvalid, m_axi_awvalid, xlat_rreq, xlat_wreq,
                              xlat_rerr, xlat_werr}, 64'd0);
    chk("rst_fields", |{m_axi_araddr, m_axi_awaddr, m_axi_arid, m_axi_awid, v_raddr, v_waddr},
        64'd0);
    @(negedge clk); reset_ = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {s_axi_arready, s_axi_awready}, 64'b11);

    for (int i = 0; i < 4; i++) run_vec(tbl[i]);

    // simultaneous AR and AW, independent handshakes
    m_axi_awready = 1'b0;
    @(negedge clk);
    s_axi_arid = 4'h2; s_axi_araddr = 32'h10; s_axi_arlen = 8'd1; s_axi_arvalid = 1'b1;
    s_axi_awid = 4'h3; s_axi_awaddr = 32'h20; s_axi_awlen = 8'd2; s_axi_awvalid = 1'b1;
    @(posedge clk); #1 s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
    lat = 0;
    while (!m_axi_arvalid && lat < 100) begin @(negedge clk); lat++; end
    chk("dual_latency", lat, 64'd42);
    chk("dual_araddr", m_axi_araddr, 64'h1010);
    chk("dual_aw_valid", {m_axi_awvalid, m_axi_awaddr, m_axi_awid}, {1'b1, 32'h1120, 4'h3});
    @(negedge clk);
    chk("dual_ar_done_aw_held", {m_axi_arvalid, m_axi_awvalid, s_axi_arready, s_axi_awready},
        64'b0110);
    m_axi_awready = 1'b1;
    @(negedge clk);
    chk("dual_aw_done", {m_axi_awvalid, s_axi_awready}, 64'b01);

    // downstream backpressure in ISSUE
    m_axi_arready = 1'b0;
    @(negedge clk);
    s_axi_arid = 4'h6; s_axi_araddr = 32'h4000; s_axi_arlen = 8'd1;
    s_axi_arsize = 3'd2; s_axi_arburst = BURST_INCR; s_axi_arvalid = 1'b1;
    @(posedge clk); #1 s_axi_arvalid = 1'b0;
    lat = 0;
    while (!m_axi_arvalid && lat < 100) begin @(negedge clk); lat++; end
    chk("bp_latency", lat, 64'd42);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {m_axi_arvalid, s_axi_arready, m_axi_araddr, m_axi_arid, m_axi_arlen,
                      m_axi_arsize, m_axi_arburst},
          {1'b1, 1'b0, 32'h5000, 4'h6, 8'd1, 3'd2, BURST_INCR});
      @(negedge clk);
    end
    m_axi_arready = 1'b1;
    @(negedge clk);
    chk("bp_release", {m_axi_arvalid, s_axi_arready}, 64'b01);

    // dut16: done in the same cycle the counter expires -> done wins
    mdl_en = 1'b0;
    do_reset();
    s_axi_arid = 4'h1; s_axi_araddr = 32'h6000; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
    @(posedge clk); #1 s_axi_arvalid = 1'b0;
    @(negedge clk);
    chk("t16_req1", b_xlat_rreq, 64'd1);
    repeat (16) @(negedge clk);
    man_rdone = 1'b1; man_raddr = 32'h0BAD_0000;
    @(negedge clk); man_rdone = 1'b0;
    chk("t16_done_wins", {b_m_axi_arvalid, b_xlat_rerr, b_xlat_rreq, b_m_axi_araddr},
        {1'b1, 1'b0, 1'b0, 32'h0BAD_0000});

    // dut16: silent translator -> retry 17 cycles later, sticky error
    @(negedge clk);
    s_axi_araddr = 32'h6100; s_axi_arvalid = 1'b1;
    @(posedge clk); #1 s_axi_arvalid = 1'b0;
    @(negedge clk); n = 1;
    chk("t16_first_req", b_xlat_rreq, 64'd1);
    do begin
      @(negedge clk); n++;
      if (n == 17) chk("t16_err_before", b_xlat_rerr, 64'd0);
    end while (!b_xlat_rreq && n < 60);
    chk("t16_retry_gap", n - 1, 64'd17);
    chk("t16_err_set", b_xlat_rerr, 64'd1);
    repeat (3) @(negedge clk);
    man_rdone = 1'b1; man_raddr = 32'h0CAF_E000;
    @(negedge clk); man_rdone = 1'b0;
    chk("t16_issue_after_retry", {b_m_axi_arvalid, b_m_axi_araddr, b_xlat_rerr},
        {1'b1, 32'h0CAF_E000, 1'b1});
    chk("main_no_err", {m_axi_arvalid, xlat_rerr}, 64'b10);
    @(negedge clk);

    // reset mid-WAIT, then a late done
    do_reset();
    s_axi_arid = 4'h7; s_axi_araddr = 32'h7000; s_axi_arlen = 8'd4; s_axi_arvalid = 1'b1;
    @(posedge clk); #1 s_axi_arvalid = 1'b0;
    repeat (10) @(negedge clk);
    reset_ = 1'b0;
    #1;
    chk("async_rst_ctrl", {m_axi_arvalid, s_axi_arready, xlat_rreq, xlat_rerr}, 64'd0);
    chk("async_rst_fields", |{m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
                              m_axi_arburst, v_raddr, r_len, r_size}, 64'd0);
    chk("async_rst_b", |{b_s_axi_arready, b_s_axi_awready, b_m_axi_arid, b_m_axi_awid,
                         b_m_axi_araddr, b_m_axi_awaddr, b_m_axi_arlen, b_m_axi_awlen,
                         b_m_axi_arsize, b_m_axi_awsize, b_m_axi_arburst, b_m_axi_awburst,
                         b_m_axi_arvalid, b_m_axi_awvalid, b_v_raddr, b_v_waddr, b_r_len,
                         b_w_len, b_r_size, b_w_size, b_xlat_rreq, b_xlat_wreq,
                         b_xlat_rerr, b_xlat_werr}, 64'd0);
    @(negedge clk); reset_ = 1'b1;
    @(negedge clk);
    man_rdone = 1'b1; man_raddr = 32'hBEEF_0000;
    @(negedge clk); man_rdone = 1'b0;
    chk("late_done_ignored", {m_axi_arvalid, s_axi_arready, m_axi_araddr}, {1'b0, 1'b1, 32'h0});

    // stray write done while idle
    man_wdone = 1'b1; man_waddr = 32'hDEAD_0000;
    @(negedge clk); man_wdone = 1'b0;
    chk("stray_wdone", {m_axi_awvalid, s_axi_awready, xlat_wreq, m_axi_awaddr},
        {1'b0, 1'b1, 1'b0, 32'h0});
    @(negedge clk);
    chk("stray_wdone_later", {m_axi_awvalid, s_axi_awready}, 64'b01);

    // normal operation after reset and stray done
    mdl_en = 1'b1;
    @(negedge clk);
    run_vec(tbl[0]);
    run_vec(tbl[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
